// File: rtl/iommu_pkg.sv
// IOMMU shared constants.
// WSI source indices and default generator sizing.
package iommu_pkg;

    localparam int WSI_SRC_CIP      = 0;
    localparam int WSI_SRC_FIP      = 1;
    localparam int WSI_SRC_PMIP     = 2;
    localparam int WSI_SRC_PIP      = 3;

    localparam int WSI_N_SRC        = 4;
    localparam int WSI_N_VEC        = 16;
    localparam int WSI_VEC_W        = 4;
    localparam int WSI_PULSE_CYCLES = 4;

endpackage

// File: rtl/iommu_wsi_pulse_ctr.sv
// Per-vector WSI wire driver.
// Level pass-through or reloadable fixed-width pulse counter.
module iommu_wsi_pulse_ctr
    import iommu_pkg::*;
#(
    parameter int PULSE_CYCLES = WSI_PULSE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load,
    input  logic clr,
    input  logic level_req,
    input  logic pulse_mode,
    output logic wsi
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A reload while running restarts the full width, so pulses merge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (pulse_mode && load) begin
            cnt_d = CW'(PULSE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            wsi   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wsi   <= pulse_mode ? (cnt_d != '0) : level_req;
        end
    end

endmodule

// File: rtl/iommu_wsi_gen.sv
// IOMMU wired-signalled interrupt generator.
// Maps ipsr pending sources onto WSI wires via icvec.
module iommu_wsi_gen
    import iommu_pkg::*;
#(
    parameter int N_SRC        = WSI_N_SRC,
    parameter int N_VEC        = WSI_N_VEC,
    parameter int VEC_W        = WSI_VEC_W,
    parameter int PULSE_CYCLES = WSI_PULSE_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wsi_en_i,
    input  logic                   pulse_mode_i,
    input  logic [N_SRC-1:0]       src_pend_i,
    input  logic [N_SRC-1:0]       src_mask_i,
    input  logic [N_SRC*VEC_W-1:0] src_vec_i,
    output logic [N_VEC-1:0]       wsi_wires_o,
    output logic                   vec_err_o
);

    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] vec_ok;
    logic [N_SRC-1:0] trig;
    logic [N_SRC-1:0] pend_q;
    logic [N_VEC-1:0] load;
    logic [N_VEC-1:0] level_req;
    logic             mode_q;
    logic             mode_vld_q;
    logic             mode_chg;
    logic             ctr_clr;

    always_comb begin
        active = src_pend_i & ~src_mask_i & {N_SRC{wsi_en_i}};
        trig   = active & ~pend_q;
        for (int s = 0; s < N_SRC; s++) begin
            vec_ok[s] = 32'(src_vec_i[s*VEC_W +: VEC_W]) < N_VEC;
        end
    end

    // Vector match implies range check, so bad vectors drive nothing.
    always_comb begin
        load      = '0;
        level_req = '0;
        for (int v = 0; v < N_VEC; v++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (src_vec_i[s*VEC_W +: VEC_W] == VEC_W'(v)) begin
                    if (active[s]) level_req[v] = 1'b1;
                    if (trig[s])   load[v]      = 1'b1;
                end
            end
        end
    end

    // First cycle out of reset has no prior mode to compare against.
    assign mode_chg = mode_vld_q && (mode_q != pulse_mode_i);
    assign ctr_clr  = !wsi_en_i || mode_chg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= '0;
            mode_q     <= 1'b0;
            mode_vld_q <= 1'b0;
            vec_err_o  <= 1'b0;
        end else begin
            pend_q     <= active;
            mode_q     <= pulse_mode_i;
            mode_vld_q <= 1'b1;
            vec_err_o  <= |(active & ~vec_ok);
        end
    end

    for (genvar v = 0; v < N_VEC; v++) begin : g_vec
        iommu_wsi_pulse_ctr #(
            .PULSE_CYCLES(PULSE_CYCLES)
        ) u_ctr (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load       (load[v]),
            .clr        (ctr_clr),
            .level_req  (level_req[v]),
            .pulse_mode (pulse_mode_i),
            .wsi        (wsi_wires_o[v])
        );
    end

endmodule
